operand_fetch_seq: RTL and testbench
====================================

// Module: operand_fetch_seq
// PURPOSE
//  Sequences the single register-file read port across the two source operands of one instruction.
//  Latches rs1/rs2 and drives the 5-bit address mux select (rf_sel=1 -> rs1, 0 -> rs2).
//  Captures read data over two cycles and presents {op_a, op_b} to execute with a valid/ready handshake.
//  Sits between decode and execute; owns the select of the regfile address mux.
// PARAMETERS
//  XLEN         32  operand / regfile data width
//  ADDR_W        5  register address width
//  ZERO_BYPASS   1  1: reads of x0 skip the port cycle and return 0; 0: x0 is read via the port
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous reset, active-low
//  flush      in   1       sync abort: drop the in-flight request, return to IDLE
//  req_valid  in   1       decode presents an instruction
//  req_ready  out  1       sequencer accepts (high only in IDLE)
//  rs1_addr   in   ADDR_W  source 1 address, sampled on accept
//  rs2_addr   in   ADDR_W  source 2 address, sampled on accept
//  need_rs2   in   1       instruction uses rs2 (0: op_b forced 0)
//  rf_rs1     out  ADDR_W  latched rs1 to the mux a-input
//  rf_rs2     out  ADDR_W  latched rs2 to the mux b-input
//  rf_sel     out  1       mux select: 1 in RD_A only, else 0
//  rf_rdata   in   XLEN    combinational regfile read data for the current mux output
//  op_valid   out  1       operands available
//  op_ready   in   1       execute consumes the operands
//  op_a       out  XLEN    operand 1 (registered)
//  op_b       out  XLEN    operand 2 (registered)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE; op_valid=0; op_a=op_b=0; rf_rs1=rf_rs2=0; rf_sel=0.
//  FSM states: IDLE, RD_A, RD_B, DONE. Accept = req_valid && req_ready.
//  IDLE: on accept, latch addresses and need_rs2. Next state:
//    RD_A if rs1 is read via the port; else RD_B if rs2 is read via the port; else DONE.
//    Skipped operands are written 0 on accept. "Read via the port": ZERO_BYPASS=0 or addr!=0; rs2 also needs need_rs2=1.
//  RD_A: rf_sel=1; op_a<=rf_rdata at the edge. Next state is RD_B if rs2 is read via the port, else DONE.
//  RD_B: rf_sel=0; op_b<=rf_rdata at the edge; next DONE.
//  DONE: op_valid=1; op_a/op_b stable; on op_ready go to IDLE (op_valid low the next cycle).
//  Latency, accept edge -> op_valid: 3 cycles with two reads; 2 with one read; 1 with none.
//  req_ready=1 only in IDLE. The cycle after op_ready, req_ready is 1 (no back-to-back accept from DONE).
//  op_ready outside DONE is ignored.
//  flush has priority over every transition except reset. State->IDLE; op_valid=0; op_a/op_b hold value.
//  flush together with an accept in IDLE: the request is dropped.
//  rst_n low mid-operation: same as reset, and the captured data is discarded.
//  rf_sel is a pure function of state (glitch-free registered state decode).
// STRUCTURE
//  Package opf_pkg: typedef enum logic [1:0] {IDLE, RD_A, RD_B, DONE} opf_state_t; localparam RF_ADDR_W=5.
//  Sub-module: the existing 5-bit mux.
//    Instance u_addr_mux(.in_a(rf_rs1), .in_b(rf_rs2), .fetch(rf_sel), .out(rf_raddr)).
//    It sits at the integration level so the regfile port sees one address.
//  Body: a single always_ff for state/latches/operands plus an always_comb for next-state and outputs.
// TESTING
//  1. rs1=5 (RF=0x11), rs2=6 (RF=0x22), need_rs2=1.
//     -> rf_sel 1 then 0; op_valid 3 cycles after accept; op_a=0x11, op_b=0x22.
//  2. rs1=0, rs2=7 (RF=0x77), ZERO_BYPASS=1 -> no RD_A cycle; op_valid after 2 cycles; op_a=0, op_b=0x77.
//  3. rs1=3 (RF=0x33), need_rs2=0 -> RD_A then DONE; op_b=0.
//     rs1=0 with need_rs2=0 -> op_valid 1 cycle after accept.
//  4. Hold op_ready=0 for 4 cycles in DONE -> op_valid and operands stable, req_ready=0.
//     op_ready=1 -> IDLE next cycle, req_ready=1.
//  5. flush asserted in RD_B -> IDLE next cycle; op_valid never rises; next request completes normally.
//  6. rst_n=0 for one cycle during RD_A -> all outputs at reset values the next cycle; req_ready=1.

Source files
------------

// File: rtl/opf_pkg.sv
// Shared types and sizes for the operand fetch sequencer.
package opf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD_A = 2'b01,
        RD_B = 2'b10,
        DONE = 2'b11
    } opf_state_t;

    localparam int RF_ADDR_W = 5;
    localparam int RF_XLEN   = 32;

endpackage

// File: rtl/operand_fetch_seq_addr_mux.sv
// Register-file read address mux: fetch=1 selects in_a (rs1), fetch=0 selects in_b (rs2).
module opf_addr_mux
    import opf_pkg::*;
#(
    parameter int W = RF_ADDR_W
) (
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         fetch,
    output logic [W-1:0] out
);

    always_comb begin
        out = fetch ? in_a : in_b;
    end

endmodule

// File: rtl/operand_fetch_seq.sv
// Sequences the single regfile read port over rs1 then rs2 and hands {op_a, op_b}
// to execute over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for decode; req_ready high
//   RD_A  | rf_sel=1, rs1 data captured into op_a at the edge
//   RD_B  | rf_sel=0, rs2 data captured into op_b at the edge
//   DONE  | op_valid high until execute takes the operands
module operand_fetch_seq
    import opf_pkg::*;
#(
    parameter int XLEN        = RF_XLEN,
    parameter int ADDR_W      = RF_ADDR_W,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              need_rs2,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    output logic              rf_sel,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]   rf_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b
);

    opf_state_t        state_q;
    opf_state_t        state_d;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic              need_rs2_q;
    logic [XLEN-1:0]   op_a_q;
    logic [XLEN-1:0]   op_b_q;

    logic              accept;
    logic              rd_a_new;
    logic              rd_b_new;
    logic              rd_b_lat;

    // An operand goes through the port unless it is x0 with bypass enabled;
    // rs2 is additionally skipped when the instruction does not use it.
    always_comb begin
        accept   = req_valid && (state_q == IDLE);
        rd_a_new = !ZERO_BYPASS || (rs1_addr != '0);
        rd_b_new = need_rs2 && (!ZERO_BYPASS || (rs2_addr != '0));
        rd_b_lat = need_rs2_q && (!ZERO_BYPASS || (rs2_q != '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            need_rs2_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else begin
            state_q <= state_d;
            // A flush freezes the latches and operands; only the state moves.
            if (!flush) begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            rs1_q      <= rs1_addr;
                            rs2_q      <= rs2_addr;
                            need_rs2_q <= need_rs2;
                            if (!rd_a_new) op_a_q <= '0;
                            if (!rd_b_new) op_b_q <= '0;
                        end
                    end
                    RD_A:    op_a_q <= rf_rdata;
                    RD_B:    op_b_q <= rf_rdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (rd_a_new)      state_d = RD_A;
                        else if (rd_b_new) state_d = RD_B;
                        else               state_d = DONE;
                    end
                end
                RD_A:    state_d = rd_b_lat ? RD_B : DONE;
                RD_B:    state_d = DONE;
                DONE:    if (op_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rf_sel    = (state_q == RD_A);
        op_valid  = (state_q == DONE);
        rf_rs1    = rs1_q;
        rf_rs2    = rs2_q;
        op_a      = op_a_q;
        op_b      = op_b_q;
    end

    opf_addr_mux #(.W(ADDR_W)) u_addr_mux (
        .in_a  (rf_rs1),
        .in_b  (rf_rs2),
        .fetch (rf_sel),
        .out   (rf_raddr)
    );

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Directed bench for operand_fetch_seq with a transaction-level latency model
// checked every cycle, plus literal expectations from hand-worked cases.
module tb_operand_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        need_rs2;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic        rf_sel;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic [31:0] rf [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_raddr];

    operand_fetch_seq #(.XLEN(32), .ADDR_W(5), .ZERO_BYPASS(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .need_rs2  (need_rs2),
        .rf_rs1    (rf_rs1),
        .rf_rs2    (rf_rs2),
        .rf_sel    (rf_sel),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a request is a countdown of L = 1 + number of port reads cycles
    // after the accept edge; cycle 1 is the rs1 read when rs1 uses the port.
    logic        m_on = 1'b0;
    logic        busy, rda, rdb, known;
    int          k, len;
    logic [4:0]  ers1, ers2;
    logic [31:0] ea, eb;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on = 1'b1; busy = 1'b0; k = 0; len = 0; rda = 1'b0; rdb = 1'b0;
            ers1 = '0; ers2 = '0; ea = '0; eb = '0; known = 1'b1;
        end else if (m_on) begin
            if (flush) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (req_valid) begin
                    rda   = (rs1_addr != 0);
                    rdb   = need_rs2 && (rs2_addr != 0);
                    len   = 1 + int'(rda) + int'(rdb);
                    k     = 1;
                    busy  = 1'b1;
                    ers1  = rs1_addr;
                    ers2  = rs2_addr;
                    ea    = rda ? rf[rs1_addr] : 32'h0;
                    eb    = rdb ? rf[rs2_addr] : 32'h0;
                    known = (len == 1);
                end
            end else if (k == len) begin
                if (op_ready) busy = 1'b0;
            end else begin
                k++;
                if (k == len) known = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, !busy});
            chk("rf_sel", {31'b0, rf_sel}, {31'b0, busy && k == 1 && rda});
            chk("op_valid", {31'b0, op_valid}, {31'b0, busy && k == len});
            chk("rf_rs1", {27'b0, rf_rs1}, {27'b0, ers1});
            chk("rf_rs2", {27'b0, rf_rs2}, {27'b0, ers2});
            chk("rf_raddr", {27'b0, rf_raddr},
                {27'b0, (busy && k == 1 && rda) ? ers1 : ers2});
            if (known) begin
                chk("op_a", op_a, ea);
                chk("op_b", op_b, eb);
            end
        end
    end

    task automatic fetch(input logic [4:0] a1, input logic [4:0] a2, input logic nd,
                         output int lat, output logic sel1);
        rs1_addr  = a1;
        rs2_addr  = a2;
        need_rs2  = nd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sel1 = rf_sel;
        lat  = 1;
        while (op_valid !== 1'b1 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
    endtask

    int   lat;
    logic s1;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'hDEAD0000;
        rf[3] = 32'h33;
        rf[5] = 32'h11;
        rf[6] = 32'h22;
        rf[7] = 32'h77;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; op_ready = 1'b0;
        rs1_addr = '0; rs2_addr = '0; need_rs2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_op_valid", {31'b0, op_valid}, 32'h0);
        chk("rst_op_a", op_a, 32'h0);
        chk("rst_rf_sel", {31'b0, rf_sel}, 32'h0);

        // two reads
        fetch(5'd5, 5'd6, 1'b1, lat, s1);
        chk("t1_latency", lat, 3);
        chk("t1_sel_first", {31'b0, s1}, 32'h1);
        chk("t1_op_a", op_a, 32'h11);
        chk("t1_op_b", op_b, 32'h22);
        consume();
        chk("t1_req_ready_after", {31'b0, req_ready}, 32'h1);

        // rs1 = x0 bypassed
        fetch(5'd0, 5'd7, 1'b1, lat, s1);
        chk("t2_latency", lat, 2);
        chk("t2_sel_first", {31'b0, s1}, 32'h0);
        chk("t2_op_a", op_a, 32'h0);
        chk("t2_op_b", op_b, 32'h77);
        consume();

        // rs2 unused
        fetch(5'd3, 5'd9, 1'b0, lat, s1);
        chk("t3_latency", lat, 2);
        chk("t3_op_a", op_a, 32'h33);
        chk("t3_op_b", op_b, 32'h0);
        consume();
        fetch(5'd0, 5'd4, 1'b0, lat, s1);
        chk("t3_nord_latency", lat, 1);
        chk("t3_nord_op_a", op_a, 32'h0);
        consume();

        // rs2 = x0 bypassed
        fetch(5'd3, 5'd0, 1'b1, lat, s1);
        chk("t3b_latency", lat, 2);
        chk("t3b_op_b", op_b, 32'h0);
        consume();

        // execute stalls in DONE
        fetch(5'd5, 5'd6, 1'b1, lat, s1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", {31'b0, op_valid}, 32'h1);
            chk("t4_hold_op_a", op_a, 32'h11);
            chk("t4_hold_op_b", op_b, 32'h22);
            chk("t4_hold_req_ready", {31'b0, req_ready}, 32'h0);
        end
        consume();
        chk("t4_req_ready", {31'b0, req_ready}, 32'h1);
        chk("t4_op_valid", {31'b0, op_valid}, 32'h0);

        // flush in RD_B; op_ready during the read is ignored
        rs1_addr = 5'd5; rs2_addr = 5'd6; need_rs2 = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        op_ready  = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t5_req_ready", {31'b0, req_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_valid", {31'b0, op_valid}, 32'h0);
            @(posedge clk); #1;
        end
        fetch(5'd3, 5'd7, 1'b1, lat, s1);
        chk("t5_next_latency", lat, 3);
        chk("t5_next_op_a", op_a, 32'h33);
        chk("t5_next_op_b", op_b, 32'h77);
        consume();

        // flush together with an accept drops the request
        rs1_addr = 5'd6; rs2_addr = 5'd5; need_rs2 = 1'b1;
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("tf_req_ready", {31'b0, req_ready}, 32'h1);
        chk("tf_rf_rs1", {27'b0, rf_rs1}, 32'h3);
        @(posedge clk); #1;
        chk("tf_no_valid", {31'b0, op_valid}, 32'h0);

        // reset during RD_A
        rs1_addr = 5'd5; rs2_addr = 5'd6; need_rs2 = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_req_ready", {31'b0, req_ready}, 32'h1);
        chk("t6_op_valid", {31'b0, op_valid}, 32'h0);
        chk("t6_rf_sel", {31'b0, rf_sel}, 32'h0);
        chk("t6_op_a", op_a, 32'h0);
        chk("t6_op_b", op_b, 32'h0);
        chk("t6_rf_rs1", {27'b0, rf_rs1}, 32'h0);
        chk("t6_rf_rs2", {27'b0, rf_rs2}, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
